// File: rtl/ps2_joy_pkg.sv
// Shared scancode constants, joystick bit indices, receiver state enum and key map
// for the PS/2-keyboard-to-joystick decoder.
package ps2_joy_pkg;

    localparam logic [7:0] ScBreak = 8'hF0;
    localparam logic [7:0] ScExt   = 8'hE0;
    localparam logic [7:0] ScE1    = 8'hE1;
    localparam logic [7:0] ScRight = 8'h74;
    localparam logic [7:0] ScLeft  = 8'h6B;
    localparam logic [7:0] ScDown  = 8'h72;
    localparam logic [7:0] ScUp    = 8'h75;
    localparam logic [7:0] ScSpace = 8'h29;
    localparam logic [7:0] ScF1    = 8'h05;
    localparam logic [7:0] ScF2    = 8'h06;
    localparam logic [7:0] ScEsc   = 8'h76;
    localparam logic [7:0] ScCtrl  = 8'h14;
    localparam logic [7:0] ScP     = 8'h4D;

    localparam int unsigned JoyW     = 10;
    localparam int unsigned JoyRight = 0;
    localparam int unsigned JoyLeft  = 1;
    localparam int unsigned JoyDown  = 2;
    localparam int unsigned JoyUp    = 3;
    localparam int unsigned JoySpace = 4;
    localparam int unsigned JoyF1    = 5;
    localparam int unsigned JoyF2    = 6;
    localparam int unsigned JoyEsc   = 7;
    localparam int unsigned JoyCtrl  = 8;
    localparam int unsigned JoyP     = 9;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDone
    } rx_state_e;

    // Arrows only count with the E0 prefix; plain codes are keypad keys.
    function automatic logic [JoyW-1:0] key_mask(input logic [7:0] code, input logic ext);
        logic [JoyW-1:0] m;
        m = '0;
        case (code)
            ScRight: m[JoyRight] = ext;
            ScLeft:  m[JoyLeft]  = ext;
            ScDown:  m[JoyDown]  = ext;
            ScUp:    m[JoyUp]    = ext;
            ScSpace: m[JoySpace] = 1'b1;
            ScF1:    m[JoyF1]    = 1'b1;
            ScF2:    m[JoyF2]    = 1'b1;
            ScEsc:   m[JoyEsc]   = 1'b1;
            ScCtrl:  m[JoyCtrl]  = 1'b1;
            ScP:     m[JoyP]     = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter and start/data/parity/stop FSM.
// Define PS2_PARITY_CHECK_EN to reject frames with even 9-bit parity.
module ps2_rx
    import ps2_joy_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 48384
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_stb_o,
    output logic [7:0] byte_o,
    output logic       err_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    logic [1:0]      clk_sync_q, data_sync_q;
    logic [3:0]      filt_hist_q;
    logic            filt_q, filt_d;
    logic [2:0]      ones;
    logic            fall, data;
    rx_state_e       state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            frame_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic            par_q, par_d;
`endif

    // 4-sample majority with hysteresis: a 2/2 split keeps the previous level.
    always_comb begin
        ones = {2'b0, filt_hist_q[0]} + {2'b0, filt_hist_q[1]}
             + {2'b0, filt_hist_q[2]} + {2'b0, filt_hist_q[3]};
        filt_d = filt_q;
        if (ones >= 3'd3) begin
            filt_d = 1'b1;
        end else if (ones <= 3'd1) begin
            filt_d = 1'b0;
        end
    end

    assign fall = filt_q & ~filt_d;
    assign data = data_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = data & (^{shift_q, par_q});
`else
    assign frame_ok = data;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tmo_d      = '0;
        byte_stb_o = 1'b0;
        err_o      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d      = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (fall && !data) begin
                    state_d   = StRecv;
                    bit_cnt_d = 4'd0;
                end
            end
            StRecv: begin
                if (fall) begin
                    if (bit_cnt_q < 4'd8) begin
                        shift_d   = {data, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (bit_cnt_q == 4'd8) begin
`ifdef PS2_PARITY_CHECK_EN
                        par_d     = data;
`endif
                        bit_cnt_d = 4'd9;
                    end else begin
                        state_d    = StDone;
                        bit_cnt_d  = 4'd0;
                        byte_stb_o = frame_ok;
                        err_o      = ~frame_ok;
                    end
                end else if (tmo_q == TmoLast) begin
                    err_o     = 1'b1;
                    state_d   = StIdle;
                    bit_cnt_d = 4'd0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_hist_q <= 4'hF;
            filt_q      <= 1'b1;
            state_q     <= StIdle;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            tmo_q       <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_q       <= 1'b0;
`endif
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            filt_hist_q <= {filt_hist_q[2:0], clk_sync_q[1]};
            filt_q      <= filt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q       <= par_d;
`endif
        end
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/ps2_joy_decoder.sv
// PS/2 keyboard to 10-bit joystick decoder: F0/E0 prefix tracking and key map over ps2_rx.
// Parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_joy_decoder
    import ps2_joy_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 48384
) (
    input  logic            clk,
    input  logic            Reset_n,
    input  logic            ps2_kbd_clk,
    input  logic            ps2_kbd_data,
    output logic [JoyW-1:0] joystick,
    output logic            scan_valid,
    output logic [7:0]      scan_code,
    output logic            frame_err
);

    logic            rx_stb, rx_err;
    logic [7:0]      rx_byte;
    logic [JoyW-1:0] joy_q, joy_d, mask;
    logic            brk_q, brk_d, ext_q, ext_d;
    logic [7:0]      code_q, code_d;
    logic            valid_q, err_q;

    ps2_rx #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk_i     (clk),
        .rst_ni    (Reset_n),
        .ps2_clk_i (ps2_kbd_clk),
        .ps2_data_i(ps2_kbd_data),
        .byte_stb_o(rx_stb),
        .byte_o    (rx_byte),
        .err_o     (rx_err)
    );

    assign mask = key_mask(rx_byte, ext_q);

    // Registering on the receiver strobe makes all outputs appear in the DONE cycle.
    always_comb begin
        joy_d  = joy_q;
        brk_d  = brk_q;
        ext_d  = ext_q;
        code_d = code_q;
        if (rx_stb) begin
            code_d = rx_byte;
            if (rx_byte == ScBreak) begin
                brk_d = 1'b1;
            end else if (rx_byte == ScExt) begin
                ext_d = 1'b1;
            end else begin
                joy_d = brk_q ? (joy_q & ~mask) : (joy_q | mask);
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            joy_q   <= '0;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            code_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            joy_q   <= joy_d;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            code_q  <= code_d;
            valid_q <= rx_stb;
            err_q   <= rx_err;
        end
    end

    assign joystick   = joy_q;
    assign scan_valid = valid_q;
    assign scan_code  = code_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_joy_decoder.sv
// Scoreboard bench for ps2_joy_decoder: expected {code, joystick} queued per sent frame,
// popped on every scan_valid pulse; honours PS2_PARITY_CHECK_EN.
module tb_ps2_joy_decoder;

    localparam int unsigned Tmo = 200;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       kclk = 1'b1;
    logic       kdat = 1'b1;
    logic [9:0] joystick;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       frame_err;

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    int err_exp = 0;
    logic prev_valid = 1'b0;
    logic [17:0] sb_q[$];

    logic [9:0] m_joy = '0;
    logic       m_brk = 1'b0;
    logic       m_ext = 1'b0;

    always #5 clk = ~clk;

    ps2_joy_decoder #(
        .TIMEOUT_CYC(Tmo)
    ) u_dut (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .ps2_kbd_clk (kclk),
        .ps2_kbd_data(kdat),
        .joystick    (joystick),
        .scan_valid  (scan_valid),
        .scan_code   (scan_code),
        .frame_err   (frame_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (scan_valid) begin
            logic [17:0] e;
            check_val("sv_width", {31'd0, prev_valid}, 32'd0);
            check_val("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_val("scan_code", {24'd0, scan_code}, {24'd0, e[17:10]});
                check_val("sb_joy", {22'd0, joystick}, {22'd0, e[9:0]});
            end
        end
        if (frame_err) err_seen++;
        prev_valid = scan_valid;
    end

    task automatic model_byte(input logic [7:0] c);
        logic [9:0] m;
        m = '0;
        if (c == 8'hF0) begin
            m_brk = 1'b1;
        end else if (c == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            case (c)
                8'h74: m[0] = m_ext;
                8'h6B: m[1] = m_ext;
                8'h72: m[2] = m_ext;
                8'h75: m[3] = m_ext;
                8'h29: m[4] = 1'b1;
                8'h05: m[5] = 1'b1;
                8'h06: m[6] = 1'b1;
                8'h76: m[7] = 1'b1;
                8'h14: m[8] = 1'b1;
                8'h4D: m[9] = 1'b1;
                default: m = '0;
            endcase
            m_joy = m_brk ? (m_joy & ~m) : (m_joy | m);
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        kdat = b;
        repeat (10) @(posedge clk);
        kclk = 1'b0;
        repeat (20) @(posedge clk);
        kclk = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic bad_par, input logic bad_stop);
        logic par;
        logic ok;
        par = (~^c) ^ bad_par;
        ok = ~bad_stop;
`ifdef PS2_PARITY_CHECK_EN
        ok = ok & ~bad_par;
`endif
        if (ok) begin
            model_byte(c);
            sb_q.push_back({c, m_joy});
        end else begin
            err_exp++;
        end
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i]);
        ps2_bit(par);
        ps2_bit(~bad_stop);
        kdat = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] c);
        send_frame(c, 1'b0, 1'b0);
    endtask

    initial begin
        #1;
        check_val("rst_joy", {22'd0, joystick}, 32'h000);
        check_val("rst_code", {24'd0, scan_code}, 32'h00);
        check_val("rst_valid", {31'd0, scan_valid}, 32'd0);
        check_val("rst_err", {31'd0, frame_err}, 32'd0);
        repeat (5) @(posedge clk);
        Reset_n = 1'b1;
        repeat (20) @(posedge clk);

        send(8'h29);
        check_val("space_make", {22'd0, joystick}, 32'h010);
        send(8'hF0); send(8'h29);
        check_val("space_brk", {22'd0, joystick}, 32'h000);

        send(8'hE0); send(8'h75); send(8'h76);
        check_val("up_esc", {22'd0, joystick}, 32'h088);
        send(8'hE0); send(8'hF0); send(8'h75);
        check_val("up_brk", {22'd0, joystick}, 32'h080);
        send(8'h75);
        check_val("ext_clr", {22'd0, joystick}, 32'h080);
        send(8'h29);
        check_val("brk_clr", {22'd0, joystick}, 32'h090);
        send(8'hF0); send(8'h29);

        send(8'h74);
        check_val("kp_right", {22'd0, joystick}, 32'h080);
        send(8'h76);
        check_val("typematic", {22'd0, joystick}, 32'h080);

        send_frame(8'h29, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check_val("bad_par", {22'd0, joystick}, 32'h080);
`else
        check_val("bad_par", {22'd0, joystick}, 32'h090);
`endif
        check_val("err_par", err_seen, err_exp);
        send(8'hF0); send(8'h29);

        send_frame(8'h29, 1'b0, 1'b1);
        check_val("bad_stop", {22'd0, joystick}, 32'h080);
        check_val("err_stop", err_seen, err_exp);

        send(8'hE1); send(8'h14);
        check_val("e1_ctrl", {22'd0, joystick}, 32'h180);

        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        err_exp++;
        repeat (Tmo + 100) @(posedge clk);
        check_val("err_tmo", err_seen, err_exp);
        send(8'h05);
        check_val("tmo_f1", {31'd0, joystick[5]}, 32'd1);
        check_val("tmo_joy", {22'd0, joystick}, 32'h1A0);

        send(8'hE0); send(8'h74); send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'h72); send(8'hE0); send(8'h75);
        send(8'h29); send(8'h06); send(8'h4D);
        check_val("all_keys", {22'd0, joystick}, 32'h3FF);

        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        kdat = 1'b1;
        repeat (10) @(posedge clk);
        kclk = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check_val("mid_rst_joy", {22'd0, joystick}, 32'h000);
        check_val("mid_rst_code", {24'd0, scan_code}, 32'h00);
        check_val("mid_rst_valid", {31'd0, scan_valid}, 32'd0);
        check_val("mid_rst_err", {31'd0, frame_err}, 32'd0);
        m_joy = '0; m_brk = 1'b0; m_ext = 1'b0;
        kclk = 1'b1;
        repeat (5) @(posedge clk);
        Reset_n = 1'b1;
        repeat (50) @(posedge clk);
        send(8'h29);
        check_val("post_rst", {22'd0, joystick}, 32'h010);

        repeat (20) @(posedge clk);
        check_val("sb_empty", sb_q.size(), 32'd0);
        check_val("err_final", err_seen, err_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_joy_decoder.md
PS2_JOY_DECODER -- requirements
Module: ps2_joy_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 48384: idle clk cycles (1 ms at 48.384 MHz) after which a partial frame is discarded.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port Reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ps2_kbd_clk  input  1  raw PS/2 clock, asynchronous.
REQ-005 SHALL have port ps2_kbd_data  input  1  raw PS/2 data, asynchronous.
REQ-006 SHALL have port joystick  output  10  held key state, 1 = pressed.
REQ-007 SHALL have port scan_valid  output  1  one-cycle pulse per accepted frame.
REQ-008 SHALL have port scan_code  output  8  last accepted byte, valid when scan_valid = 1.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a framing, parity or timeout error.

Function
REQ-010 SHALL pass both PS/2 inputs through 2-FF synchronizers, then a 4-sample majority glitch filter on the clock line.
REQ-011 SHALL sample data on each filtered ps2_kbd_clk falling edge.
REQ-012 SHALL implement receiver FSM IDLE -> RECV -> DONE -> IDLE.
REQ-013 SHALL leave IDLE only when the sampled start bit is 0; a sampled 1 is ignored and the FSM stays in IDLE.
REQ-014 SHALL shift data LSB-first in RECV; the 4-bit bit counter counts data bits 0..7, then parity, then stop.
REQ-015 SHALL enter DONE on the stop-bit edge and return to IDLE on the next cycle.
REQ-016 SHALL accept a frame only when stop = 1 (and parity is odd, see REQ-027).
REQ-017 SHALL, for an accepted frame, assert scan_valid and scan_code exactly 1 clk after the stop-bit edge is detected; joystick updates in that same cycle.
REQ-018 SHALL, for a rejected frame, pulse frame_err in that cycle and leave joystick, scan_code and the prefix flags unchanged.
REQ-019 SHALL, when TIMEOUT_CYC cycles elapse in RECV with no falling edge, pulse frame_err, clear the bit counter and return to IDLE.
REQ-020 SHALL have decoder flags brk and ext: byte F0 sets brk, byte E0 sets ext, and neither prefix updates joystick.
REQ-021 SHALL, on any other byte, apply that byte's key mapping with value ~brk, then clear brk and ext.
REQ-022 SHALL map bits as follows, where E0 means the key needs ext = 1:
  - bit0 = E0 74 (right), bit1 = E0 6B (left), bit2 = E0 72 (down), bit3 = E0 75 (up);
  - bit4 = 29 (space), bit5 = 05 (F1), bit6 = 06 (F2), bit7 = 76 (Esc), bit8 = 14 (ctrl, with or without E0), bit9 = 4D (P).
REQ-023 SHALL ignore arrow codes when ext = 0 (keypad keys) and ignore unmapped codes and E1; flags still clear.
REQ-024 SHALL make a repeated make code (typematic) idempotent, with no toggling.

Reset
REQ-025 SHALL, while Reset_n = 0, force:
  - FSM to IDLE; bit counter, timeout counter, brk and ext to 0;
  - joystick = 10'h000, scan_code = 8'h00, scan_valid = 0, frame_err = 0;
  - synchronizers and glitch filter to 1 (bus idle).
REQ-026 SHALL, on reset release mid-frame, wait for the next start bit; remaining bits of the interrupted frame are not decoded as a frame.

Configuration
REQ-027 SHALL, with macro PS2_PARITY_CHECK_EN defined, reject frames whose 9 bits (data plus parity) have even parity.
REQ-028 SHALL, without PS2_PARITY_CHECK_EN, ignore the parity bit and assert frame_err only on stop = 0 or timeout.

Structure
REQ-029 SHALL place in shared package ps2_joy_pkg:
  - scancode constants (F0, E0, E1, mapped keys);
  - joystick bit index constants;
  - the receiver FSM state enum.
REQ-030 SHALL implement the frame receiver (REQ-010..019) as sub-module ps2_rx; the decoder and key map stay in ps2_joy_decoder.

Verification
REQ-031 SHALL verify: frame 29 (odd parity) -> scan_valid pulse, scan_code = 29, joystick = 10'h010; then F0 29 -> joystick = 10'h000.
REQ-032 SHALL verify: E0 75 then 76 -> joystick = 10'h088; then E0 F0 75 -> joystick = 10'h080, with ext and brk cleared.
REQ-033 SHALL verify: 74 without E0 -> joystick unchanged, scan_valid pulses, flags clear.
REQ-034 SHALL verify: 29 with a bad parity bit -> frame_err pulse and joystick unchanged (macro defined); without the macro -> bit4 set.
REQ-035 SHALL verify: 5 bits of a frame, then a 1.2 ms gap, then a full 05 frame -> one frame_err pulse, then joystick bit5 = 1.
REQ-036 SHALL verify: Reset_n asserted mid-frame with joystick = 10'h3FF -> all outputs 0 immediately; next valid frame decodes correctly.
